// File: rtl/toe_cam_client.sv
// toe_cam_client: initiator side of the TOE session CAM lookup/update interfaces.
// Optional statistics counters are compiled in when TOE_CAM_CLIENT_STATS_EN is defined.
module toe_cam_client #(
    parameter int K       = 96,
    parameter int V       = 14,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_done,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [K-1:0] req_key,
    input  logic         req_allocate,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_hit,
    output logic         rsp_new,
    output logic [K-1:0] rsp_key,
    output logic [V-1:0] rsp_value,
    input  logic         del_valid,
    output logic         del_ready,
    input  logic [K-1:0] del_key,
    input  logic         free_id_valid,
    output logic         free_id_ready,
    input  logic [V-1:0] free_id,
    output logic         lookup_req_valid,
    output logic [K-1:0] lookup_req_key,
    input  logic         lookup_resp_valid,
    input  logic         lookup_resp_hit,
    input  logic [K-1:0] lookup_resp_key,
    input  logic [V-1:0] lookup_resp_value,
    input  logic         update_ready,
    output logic         update_valid,
    output logic         update_op,
    output logic [K-1:0] update_key,
    output logic         update_static,
    output logic [V-1:0] update_value,
`ifdef TOE_CAM_CLIENT_STATS_EN
    output logic [31:0]  stat_lookups,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_inserts,
    output logic [31:0]  stat_deletes,
`endif
    output logic         err_timeout
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT - 1);

    // state   | meaning
    // IDLE    | inspect response FIFO head, or start a pending delete when FIFO empty
    // WAIT_ID | waiting for a free session ID for an insert-on-miss
    // INSERT  | CAM insert of (head key, fresh ID) until accepted
    // DELETE  | CAM delete of latched key until accepted
    // RESP    | present response to TOE until accepted, then pop head
    typedef enum logic [2:0] {S_IDLE, S_WAIT_ID, S_INSERT, S_DELETE, S_RESP} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] outstanding, fifo_count;
    logic [PW-1:0] tag_wr, tag_rd, rf_wr, rf_rd;
    logic [WW-1:0] wd_cnt;
    logic          tag_mem  [DEPTH];
    logic          rf_hit   [DEPTH];
    logic          rf_alloc [DEPTH];
    logic [K-1:0]  rf_key   [DEPTH];
    logic [V-1:0]  rf_value [DEPTH];

    logic         accept, resp_take, wd_fire, head_valid, head_pop;
    logic         h_hit, h_alloc;
    logic [K-1:0] h_key;
    logic [V-1:0] h_value;

    logic         last_ins_valid;
    logic [K-1:0] last_ins_key;
    logic [V-1:0] last_ins_value;
    logic [V-1:0] id_q;
    logic [K-1:0] del_key_q;
    logic         del_first;
    logic         rsp_hit_q, rsp_new_q;
    logic [V-1:0] rsp_value_q;

    logic         load_rsp, rsp_hit_nxt, rsp_new_nxt, take_id, del_start, ins_done, del_done;
    logic [V-1:0] rsp_value_nxt;

    assign req_ready  = init_done & (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
    assign accept     = req_valid & req_ready;
    assign resp_take  = lookup_resp_valid & (outstanding != '0);
    assign wd_fire    = (outstanding != '0) & ~lookup_resp_valid & (wd_cnt == '0);
    assign head_valid = (fifo_count != '0);
    assign head_pop   = (state == S_RESP) & rsp_ready;

    assign h_hit   = rf_hit[rf_rd];
    assign h_alloc = rf_alloc[rf_rd];
    assign h_key   = rf_key[rf_rd];
    assign h_value = rf_value[rf_rd];

    assign rsp_hit       = rsp_hit_q;
    assign rsp_new       = rsp_new_q;
    assign rsp_value     = rsp_value_q;
    assign rsp_key       = h_key;
    assign update_static = 1'b0;

    // A watchdog expiry abandons every in-flight tag; a same-cycle accept survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_req_valid <= 1'b0;
            lookup_req_key   <= '0;
            outstanding      <= '0;
            tag_wr           <= '0;
            tag_rd           <= '0;
            wd_cnt           <= WD_LOAD;
            err_timeout      <= 1'b0;
        end else begin
            lookup_req_valid <= accept;
            if (accept) begin
                lookup_req_key <= req_key;
                tag_wr         <= tag_wr + 1'b1;
            end
            if (wd_fire) begin
                err_timeout <= 1'b1;
                tag_rd      <= tag_wr;
                outstanding <= CW'(accept);
            end else begin
                if (resp_take) tag_rd <= tag_rd + 1'b1;
                outstanding <= outstanding + CW'(accept) - CW'(resp_take);
            end
            if ((outstanding == '0) || lookup_resp_valid || wd_fire) wd_cnt <= WD_LOAD;
            else                                                       wd_cnt <= wd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wr] <= req_allocate;
        if (resp_take) begin
            rf_hit[rf_wr]   <= lookup_resp_hit;
            rf_key[rf_wr]   <= lookup_resp_key;
            rf_value[rf_wr] <= lookup_resp_value;
            rf_alloc[rf_wr] <= tag_mem[tag_rd];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr      <= '0;
            rf_rd      <= '0;
            fifo_count <= '0;
        end else begin
            if (resp_take) rf_wr <= rf_wr + 1'b1;
            if (head_pop)  rf_rd <= rf_rd + 1'b1;
            fifo_count <= fifo_count + CW'(resp_take) - CW'(head_pop);
        end
    end

    always_comb begin
        state_nxt     = state;
        load_rsp      = 1'b0;
        rsp_hit_nxt   = 1'b0;
        rsp_new_nxt   = 1'b0;
        rsp_value_nxt = h_value;
        take_id       = 1'b0;
        del_start     = 1'b0;
        ins_done      = 1'b0;
        del_done      = 1'b0;
        free_id_ready = 1'b0;
        del_ready     = 1'b0;
        update_valid  = 1'b0;
        update_op     = 1'b0;
        update_key    = h_key;
        update_value  = id_q;
        rsp_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_valid) begin
                    if (h_hit || !h_alloc) begin
                        state_nxt   = S_RESP;
                        load_rsp    = 1'b1;
                        rsp_hit_nxt = h_hit;
                    end else if (last_ins_valid && (h_key == last_ins_key)) begin
                        // Key inserted moments ago but looked up before the CAM saw it.
                        state_nxt     = S_RESP;
                        load_rsp      = 1'b1;
                        rsp_hit_nxt   = 1'b1;
                        rsp_value_nxt = last_ins_value;
                    end else begin
                        state_nxt = S_WAIT_ID;
                    end
                end else if (del_valid && init_done) begin
                    state_nxt = S_DELETE;
                    del_start = 1'b1;
                end
            end
            S_WAIT_ID: begin
                free_id_ready = 1'b1;
                if (free_id_valid) begin
                    take_id   = 1'b1;
                    state_nxt = S_INSERT;
                end
            end
            S_INSERT: begin
                update_valid = 1'b1;
                if (update_ready) begin
                    ins_done      = 1'b1;
                    load_rsp      = 1'b1;
                    rsp_hit_nxt   = 1'b1;
                    rsp_new_nxt   = 1'b1;
                    rsp_value_nxt = id_q;
                    state_nxt     = S_RESP;
                end
            end
            S_DELETE: begin
                del_ready    = del_first;
                update_valid = 1'b1;
                update_op    = 1'b1;
                update_key   = del_key_q;
                update_value = '0;
                if (update_ready) begin
                    del_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            id_q           <= '0;
            del_key_q      <= '0;
            del_first      <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_new_q      <= 1'b0;
            rsp_value_q    <= '0;
            last_ins_valid <= 1'b0;
            last_ins_key   <= '0;
            last_ins_value <= '0;
        end else begin
            state     <= state_nxt;
            del_first <= del_start;
            if (take_id)   id_q      <= free_id;
            if (del_start) del_key_q <= del_key;
            if (load_rsp) begin
                rsp_hit_q   <= rsp_hit_nxt;
                rsp_new_q   <= rsp_new_nxt;
                rsp_value_q <= rsp_value_nxt;
            end
            if (ins_done) begin
                last_ins_valid <= 1'b1;
                last_ins_key   <= h_key;
                last_ins_value <= id_q;
            end else if (del_done && (del_key_q == last_ins_key)) begin
                last_ins_valid <= 1'b0;
            end
        end
    end

`ifdef TOE_CAM_CLIENT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_inserts <= '0;
            stat_deletes <= '0;
        end else begin
            if (lookup_req_valid)                  stat_lookups <= stat_lookups + 1'b1;
            if (resp_take && lookup_resp_hit)      stat_hits    <= stat_hits + 1'b1;
            if (ins_done)                          stat_inserts <= stat_inserts + 1'b1;
            if (del_ready && del_valid)            stat_deletes <= stat_deletes + 1'b1;
        end
    end
`endif

endmodule
